// File: rtl/riscv_core_hazard_ctrl_pkg.sv
// rtl/riscv_core_hazard_ctrl_pkg.sv - shared encodings and stage tuple for the hazard controller
package riscv_core_ctrl_pkg;

  // Decode-stage operand bypass mux encoding
  typedef enum logic [1:0] {
    BYP_RF = 2'd0,
    BYP_X  = 2'd1,
    BYP_M  = 2'd2,
    BYP_W  = 2'd3
  } byp_sel_e;

  // PC mux encoding
  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_BR    = 2'd1,
    PC_JAL   = 2'd2,
    PC_JALR  = 2'd3
  } pc_sel_e;

  // Writer state carried by each downstream stage
  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] rd;
  } stage_t;

endpackage

// File: rtl/riscv_core_hazard_ctrl_if.sv
// rtl/riscv_core_hazard_ctrl_if.sv - datapath <-> hazard controller signal bundle
interface riscv_core_hazard_ctrl_if;
  logic       inst_val_Dhl;
  logic       rs1_en_Dhl;
  logic       rs2_en_Dhl;
  logic [4:0] rs1_addr_Dhl;
  logic [4:0] rs2_addr_Dhl;
  logic       rd_wen_Dhl;
  logic [4:0] rd_addr_Dhl;
  logic       is_load_Dhl;
  logic       is_muldiv_Dhl;
  logic       jal_Dhl;
  logic       jalr_Dhl;
  logic       br_taken_Xhl;
  logic       dmem_wait_Mhl;
  logic       muldivresp_val;

  logic [1:0] rs1_byp_mux_sel_Dhl;
  logic [1:0] rs2_byp_mux_sel_Dhl;
  logic [1:0] pc_mux_sel_Phl;
  logic       squash_Dhl;
  logic       stall_Fhl;
  logic       stall_Dhl;
  logic       stall_Xhl;
  logic       stall_Mhl;
  logic       stall_Whl;
  logic       rf_wen_Whl;
  logic [4:0] rf_waddr_Whl;

  // Datapath side: supplies decode fields and unit status, consumes control
  modport master (
    output inst_val_Dhl, rs1_en_Dhl, rs2_en_Dhl, rs1_addr_Dhl, rs2_addr_Dhl,
           rd_wen_Dhl, rd_addr_Dhl, is_load_Dhl, is_muldiv_Dhl, jal_Dhl, jalr_Dhl,
           br_taken_Xhl, dmem_wait_Mhl, muldivresp_val,
    input  rs1_byp_mux_sel_Dhl, rs2_byp_mux_sel_Dhl, pc_mux_sel_Phl, squash_Dhl,
           stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl,
           rf_wen_Whl, rf_waddr_Whl
  );

  // Controller side
  modport slave (
    input  inst_val_Dhl, rs1_en_Dhl, rs2_en_Dhl, rs1_addr_Dhl, rs2_addr_Dhl,
           rd_wen_Dhl, rd_addr_Dhl, is_load_Dhl, is_muldiv_Dhl, jal_Dhl, jalr_Dhl,
           br_taken_Xhl, dmem_wait_Mhl, muldivresp_val,
    output rs1_byp_mux_sel_Dhl, rs2_byp_mux_sel_Dhl, pc_mux_sel_Phl, squash_Dhl,
           stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl,
           rf_wen_Whl, rf_waddr_Whl
  );
endinterface

// File: rtl/riscv_core_byp_sel.sv
// rtl/riscv_core_byp_sel.sv - per-operand writer match and bypass priority encoder
module riscv_core_byp_sel
  import riscv_core_ctrl_pkg::*;
(
  input  logic       en,
  input  logic [4:0] addr,
  input  stage_t     x_stage,
  input  logic       is_load_x,
  input  stage_t     m_stage,
  input  stage_t     w_stage,
  output logic [1:0] sel,
  output logic       x_load_match
);

  logic rd_live;
  logic match_x;
  logic match_m;
  logic match_w;

  // x0 is hardwired, so it never takes a bypass
  assign rd_live = en && (addr != 5'd0);
  assign match_x = rd_live && x_stage.val && x_stage.wen && (x_stage.rd == addr);
  assign match_m = rd_live && m_stage.val && m_stage.wen && (m_stage.rd == addr);
  assign match_w = rd_live && w_stage.val && w_stage.wen && (w_stage.rd == addr);

  // Youngest writer wins: X over M over W over the register file
  always_comb begin
    sel          = BYP_RF;
    x_load_match = match_x && is_load_x;
    if (match_x)      sel = BYP_X;
    else if (match_m) sel = BYP_M;
    else if (match_w) sel = BYP_W;
  end

endmodule

// File: rtl/riscv_core_hazard_ctrl.sv
// rtl/riscv_core_hazard_ctrl.sv - X/M/W scoreboard driving bypass, stall, redirect and writeback
module riscv_core_hazard_ctrl
  import riscv_core_ctrl_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  riscv_core_hazard_ctrl_if.slave hz
);

  stage_t x_q, m_q, w_q;
  logic   is_load_x_q;
  logic   is_muldiv_x_q;

  logic   rs1_en, rs2_en;
  logic   rs1_load_match, rs2_load_match;
  logic   load_use;
  logic   muldiv_busy;
  logic   br_redirect;
  logic   jump_redirect;
  logic   stall_d, stall_x, stall_m;

  // Operand enables are only meaningful for a real D instruction
  assign rs1_en = hz.inst_val_Dhl & hz.rs1_en_Dhl;
  assign rs2_en = hz.inst_val_Dhl & hz.rs2_en_Dhl;

  riscv_core_byp_sel u_byp_rs1 (
    .en           (rs1_en),
    .addr         (hz.rs1_addr_Dhl),
    .x_stage      (x_q),
    .is_load_x    (is_load_x_q),
    .m_stage      (m_q),
    .w_stage      (w_q),
    .sel          (hz.rs1_byp_mux_sel_Dhl),
    .x_load_match (rs1_load_match)
  );

  riscv_core_byp_sel u_byp_rs2 (
    .en           (rs2_en),
    .addr         (hz.rs2_addr_Dhl),
    .x_stage      (x_q),
    .is_load_x    (is_load_x_q),
    .m_stage      (m_q),
    .w_stage      (w_q),
    .sel          (hz.rs2_byp_mux_sel_Dhl),
    .x_load_match (rs2_load_match)
  );

  // Stall chain and redirect: a taken branch kills D instead of stalling it
  always_comb begin
    load_use      = rs1_load_match | rs2_load_match;
    muldiv_busy   = x_q.val & is_muldiv_x_q & ~hz.muldivresp_val;
    stall_m       = hz.dmem_wait_Mhl;
    stall_x       = stall_m | muldiv_busy;
    br_redirect   = hz.br_taken_Xhl & x_q.val & ~stall_x;
    stall_d       = stall_x | (load_use & ~br_redirect);
    jump_redirect = hz.inst_val_Dhl & (hz.jal_Dhl | hz.jalr_Dhl) & ~stall_d & ~br_redirect;

    hz.pc_mux_sel_Phl = PC_PLUS4;
    if (br_redirect)                  hz.pc_mux_sel_Phl = PC_BR;
    else if (jump_redirect & hz.jal_Dhl) hz.pc_mux_sel_Phl = PC_JAL;
    else if (jump_redirect)           hz.pc_mux_sel_Phl = PC_JALR;

    hz.squash_Dhl   = br_redirect | jump_redirect;
    hz.stall_Mhl    = stall_m;
    hz.stall_Xhl    = stall_x;
    hz.stall_Dhl    = stall_d;
    hz.stall_Fhl    = stall_d;
    hz.stall_Whl    = 1'b0;
    hz.rf_wen_Whl   = w_q.val & w_q.wen;
    hz.rf_waddr_Whl = w_q.rd;
  end

  // Advance X/M/W, injecting cleared bubbles where the upstream stage cannot move
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q           <= '0;
      m_q           <= '0;
      w_q           <= '0;
      is_load_x_q   <= 1'b0;
      is_muldiv_x_q <= 1'b0;
    end else begin
      if (!stall_x) begin
        if (!hz.inst_val_Dhl || stall_d || br_redirect) begin
          x_q           <= '0;
          is_load_x_q   <= 1'b0;
          is_muldiv_x_q <= 1'b0;
        end else begin
          x_q.val       <= 1'b1;
          x_q.wen       <= hz.rd_wen_Dhl;
          x_q.rd        <= hz.rd_addr_Dhl;
          is_load_x_q   <= hz.is_load_Dhl;
          is_muldiv_x_q <= hz.is_muldiv_Dhl;
        end
      end
      if (!stall_m) begin
        m_q <= stall_x ? '0 : x_q;
      end
      w_q <= stall_m ? '0 : m_q;
    end
  end

endmodule

// File: tb/tb_riscv_core_hazard_ctrl.sv
// tb/tb_riscv_core_hazard_ctrl.sv - scoreboard bench for the hazard controller
module tb_riscv_core_hazard_ctrl;

  typedef struct packed {
    logic       val;
    logic       r1en;
    logic [4:0] r1;
    logic       r2en;
    logic [4:0] r2;
    logic       wen;
    logic [4:0] rd;
    logic       ld;
    logic       md;
    logic       jal;
    logic       jalr;
    logic       br;
    logic       dwait;
    logic       mdresp;
  } dvec_t;

  typedef struct packed {
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] pc;
    logic       sq;
    logic       sf;
    logic       sd;
    logic       sx;
    logic       sm;
    logic       sw;
    logic       wen;
    logic [4:0] waddr;
  } exp_t;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   id_q[$];

  riscv_core_hazard_ctrl_if hz();

  riscv_core_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic dvec_t nop();
    dvec_t d;
    d = '0;
    return d;
  endfunction

  function automatic dvec_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic e1,
                                input logic [4:0] rs2, input logic e2);
    dvec_t d;
    d      = '0;
    d.val  = 1'b1;
    d.wen  = 1'b1;
    d.rd   = rd;
    d.r1   = rs1;
    d.r1en = e1;
    d.r2   = rs2;
    d.r2en = e2;
    return d;
  endfunction

  function automatic exp_t ex(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] pc,
                              input logic sq, input logic sd, input logic sx, input logic sm,
                              input logic wen, input logic [4:0] wa);
    exp_t e;
    e.s1 = s1; e.s2 = s2; e.pc = pc; e.sq = sq;
    e.sf = sd; e.sd = sd; e.sx = sx; e.sm = sm; e.sw = 1'b0;
    e.wen = wen; e.waddr = wa;
    return e;
  endfunction

  task automatic drive(input dvec_t d);
    hz.inst_val_Dhl   = d.val;
    hz.rs1_en_Dhl     = d.r1en;
    hz.rs1_addr_Dhl   = d.r1;
    hz.rs2_en_Dhl     = d.r2en;
    hz.rs2_addr_Dhl   = d.r2;
    hz.rd_wen_Dhl     = d.wen;
    hz.rd_addr_Dhl    = d.rd;
    hz.is_load_Dhl    = d.ld;
    hz.is_muldiv_Dhl  = d.md;
    hz.jal_Dhl        = d.jal;
    hz.jalr_Dhl       = d.jalr;
    hz.br_taken_Xhl   = d.br;
    hz.dmem_wait_Mhl  = d.dwait;
    hz.muldivresp_val = d.mdresp;
  endtask

  task automatic step(input dvec_t d, input exp_t e, input logic rst);
    @(posedge clk);
    #1;
    reset = rst;
    drive(d);
    exp_q.push_back(e);
    id_q.push_back(cyc);
    cyc++;
  endtask

  // Monitor: compare the combinational outputs mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      int   id;
      e = exp_q.pop_front();
      id = id_q.pop_front();
      a.s1 = hz.rs1_byp_mux_sel_Dhl; a.s2 = hz.rs2_byp_mux_sel_Dhl; a.pc = hz.pc_mux_sel_Phl;
      a.sq = hz.squash_Dhl; a.sf = hz.stall_Fhl; a.sd = hz.stall_Dhl; a.sx = hz.stall_Xhl;
      a.sm = hz.stall_Mhl; a.sw = hz.stall_Whl; a.wen = hz.rf_wen_Whl; a.waddr = hz.rf_waddr_Whl;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cyc%0d: got s1=%0d s2=%0d pc=%0d sq=%b stF/D/X/M/W=%b%b%b%b%b wen=%b wa=%0d, want s1=%0d s2=%0d pc=%0d sq=%b stF/D/X/M/W=%b%b%b%b%b wen=%b wa=%0d",
                 id, a.s1, a.s2, a.pc, a.sq, a.sf, a.sd, a.sx, a.sm, a.sw, a.wen, a.waddr,
                 e.s1, e.s2, e.pc, e.sq, e.sf, e.sd, e.sx, e.sm, e.sw, e.wen, e.waddr);
      end
    end
  end

  initial begin
    dvec_t d;
    exp_t  z;
    z = ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    drive(nop());

    // reset state
    step(nop(), z, 0);                                           // 0
    // back-to-back ALU dependency, then one-nop gap
    step(alu(1, 0, 1, 0, 0), z, 0);                              // 1 addi x1
    step(alu(2, 1, 1, 1, 1), ex(1, 1, 0, 0, 0, 0, 0, 0, 0), 0);  // 2 add x2,x1,x1
    step(nop(), z, 0);                                           // 3
    step(alu(6, 2, 1, 2, 1), ex(2, 2, 0, 0, 0, 0, 0, 1, 1), 0);  // 4 add x6,x2,x2
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 2), 0);               // 5
    step(nop(), z, 0);                                           // 6
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 6), 0);               // 7
    // load-use, then memory wait for two cycles
    d = alu(3, 0, 1, 0, 0); d.ld = 1'b1;
    step(d, z, 0);                                               // 8 lw x3
    d = alu(4, 3, 1, 0, 1);
    step(d, ex(1, 0, 0, 0, 1, 0, 0, 0, 0), 0);                   // 9 load-use stall
    d.dwait = 1'b1;
    step(d, ex(2, 0, 0, 0, 1, 1, 1, 0, 0), 0);                   // 10
    step(d, ex(2, 0, 0, 0, 1, 1, 1, 0, 0), 0);                   // 11
    d.dwait = 1'b0;
    step(d, ex(2, 0, 0, 0, 0, 0, 0, 0, 0), 0);                   // 12
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 3), 0);               // 13
    step(nop(), z, 0);                                           // 14
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 4), 0);               // 15
    // mul/div pending for three cycles with a consumer waiting in D
    d = alu(5, 0, 0, 0, 0); d.md = 1'b1;
    step(d, z, 0);                                               // 16 mul x5
    d = alu(8, 5, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(d, ex(1, 0, 0, 0, 1, 1, 0, 0, 0), 0);                 // 17..19
    d.mdresp = 1'b1;
    step(d, ex(1, 0, 0, 0, 0, 0, 0, 0, 0), 0);                   // 20
    step(nop(), z, 0);                                           // 21
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 5), 0);               // 22
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 8), 0);               // 23
    // taken branch in X beats jal in D
    d = alu(0, 0, 0, 0, 0); d.wen = 1'b0;
    step(d, z, 0);                                               // 24 branch
    d = alu(1, 0, 0, 0, 0); d.jal = 1'b1; d.br = 1'b1;
    step(d, ex(0, 0, 1, 1, 0, 0, 0, 0, 0), 0);                   // 25
    for (int i = 0; i < 4; i++) step(nop(), z, 0);               // 26..29
    // standalone jal, then jalr bypassing its link register from M
    d = alu(1, 0, 0, 0, 0); d.jal = 1'b1;
    step(d, ex(0, 0, 2, 1, 0, 0, 0, 0, 0), 0);                   // 30
    step(nop(), z, 0);                                           // 31
    d = alu(9, 1, 1, 0, 0); d.jalr = 1'b1;
    step(d, ex(2, 0, 3, 1, 0, 0, 0, 0, 0), 0);                   // 32
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 1), 0);               // 33
    step(nop(), z, 0);                                           // 34
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 9), 0);               // 35
    // x0 never bypasses; x7 writers in X and W choose X
    step(alu(0, 0, 0, 0, 0), z, 0);                              // 36 addi x0
    step(alu(10, 0, 1, 0, 1), z, 0);                             // 37 reads x0
    step(alu(7, 0, 0, 0, 0), z, 0);                              // 38
    step(nop(), ex(0, 0, 0, 0, 0, 0, 0, 1, 0), 0);               // 39
    step(alu(7, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 1, 10), 0); // 40
    step(alu(11, 7, 1, 7, 1), ex(1, 1, 0, 0, 0, 0, 0, 1, 7), 0); // 41
    step(alu(12, 7, 1, 0, 1), ex(2, 0, 0, 0, 0, 0, 0, 0, 0), 0); // 42
    // fill the pipe, then reset with every stage valid
    step(alu(16, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 1, 7), 0);  // 43
    step(alu(13, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 1, 11), 0); // 44
    step(alu(14, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 1, 12), 0); // 45
    step(alu(15, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 1, 16), 1); // 46 reset asserted
    d = alu(17, 14, 1, 13, 1); d.val = 1'b0; d.jal = 1'b1;
    step(d, z, 0);                                               // 47 unqualified D ignored
    step(nop(), z, 0);                                           // 48
    step(nop(), z, 0);                                           // 49

    @(posedge clk);
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_core_hazard_ctrl.md
# riscv_core_hazard_ctrl

Pipeline hazard controller for the 5-stage bypassed RISC-V core. It tracks destination and valid state for the X, M and W stages, and drives the decode-stage bypass mux selects, the per-stage stall signals, the PC mux select and the writeback enable. It sits beside the core datapath and takes decoded fields from the D stage plus status from the mul/div unit and the data-memory port.

## Interface
Parameters: none.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_val_Dhl  in  1  D holds a real (unsquashed) instruction
- rs1_en_Dhl / rs2_en_Dhl  in  1  operand is read
- rs1_addr_Dhl / rs2_addr_Dhl  in  5  source registers
- rd_wen_Dhl  in  1  instruction writes rd
- rd_addr_Dhl  in  5  destination
- is_load_Dhl  in  1  load
- is_muldiv_Dhl  in  1  mul/div op
- jal_Dhl / jalr_Dhl  in  1  jump decoded in D
- br_taken_Xhl  in  1  branch in X resolved taken (datapath condition already applied)
- dmem_wait_Mhl  in  1  load/store in M has no response this cycle
- muldivresp_val  in  1  mul/div result valid in X
- rs1_byp_mux_sel_Dhl / rs2_byp_mux_sel_Dhl  out  2  0 = RF, 1 = X, 2 = M, 3 = W
- pc_mux_sel_Phl  out  2  0 = pc+4, 1 = branch, 2 = jal, 3 = jalr
- squash_Dhl  out  1  invalidate the instruction entering D next edge
- stall_Fhl, stall_Dhl, stall_Xhl, stall_Mhl, stall_Whl  out  1  stage hold
- rf_wen_Whl  out  1  regfile write enable
- rf_waddr_Whl  out  5  regfile write address

## Operation
- Per-stage state for X, M and W: val, wen, rd, is_load (X only), is_muldiv (X only). It advances on each edge unless the stage is stalled.
- A stage that advances while the stage before it is stalled or squashed receives a bubble (val = 0).
- Writer in stage S "matches" operand r when all of these hold: val_S, wen_S, rd_S == r, r != 0, and the operand's en is set.
- Bypass priority is X > M > W > RF, evaluated independently per operand. x0 always selects RF.
- Load-use hazard: X holds a valid load that matches rs1 or rs2 → stall D and send a bubble to X.
- Mul/div: stall_Xhl = stall_Mhl | (val_X & is_muldiv_X & !muldivresp_val). An X-match on a pending mul/div is covered by the resulting D stall.
- Stalls:
  - stall_Mhl = dmem_wait_Mhl
  - stall_Whl = 0
  - stall_Dhl = stall_Xhl | load_use
  - stall_Fhl = stall_Dhl
  - When M is stalled, W receives a bubble.
- Redirect, in priority order:
  - br_taken_Xhl & val_X & !stall_Xhl → pc_mux_sel = 1, squash_Dhl = 1. The D instruction is also killed: bubble into X.
  - Otherwise, jal_Dhl or jalr_Dhl with inst_val_Dhl & !stall_Dhl → sel 2 or 3, squash_Dhl = 1.
  - Otherwise sel = 0.
  - jalr waits on load-use for rs1 through stall_Dhl.
- rf_wen_Whl = val_W & wen_W. rf_waddr_Whl = rd_W.
- D-stage inputs are qualified by inst_val_Dhl. If it is 0, no hazard and no jump is reported.

## Timing
- All outputs are combinational from registered stage state plus the current D inputs. No added latency.
- An instruction reaches W 3 edges after leaving D, absent stalls.
- Reset: all val bits = 0 at the next edge. Outputs then read:
  - stalls 0, byp selects 0, pc_mux_sel 0, squash 0, rf_wen_Whl 0, rf_waddr_Whl 0.
- Reset mid-operation discards in-flight work. A muldivresp_val arriving while val_X = 0 is ignored.
- Simultaneous events:
  - Branch taken in X and jump in D → branch wins.
  - Load-use and a taken branch in the same cycle → squash wins; the D instruction is killed, not stalled.
  - Matches in X and M on the same register → X is selected.

## Structure
- Package riscv_core_ctrl_pkg holds:
  - BYP_RF / BYP_X / BYP_M / BYP_W
  - PC_PLUS4 / PC_BR / PC_JAL / PC_JALR
- Sub-module riscv_core_byp_sel: per-operand match and priority encoder (inputs: operand en/addr and the three stage tuples; outputs: 2-bit select and an X-load-match flag). It is instantiated twice.

## Test plan
- addi x1 then add x2,x1,x1 back-to-back → both selects = 1 (X), no stall. One intervening nop → selects = 2 (M).
- lw x3 then add x4,x3,x0 → stall_Dhl = 1 for one cycle with a bubble in X, then rs1 select = 2 (M). With dmem_wait_Mhl held 2 cycles → stall_Mhl, stall_Xhl and stall_Dhl all stay high for 2 cycles.
- mul x5 with muldivresp_val low for 3 cycles → stall_Xhl = stall_Dhl = 1 for 3 cycles. A consumer in D then gets select 1 on the cycle muldivresp_val = 1.
- br_taken_Xhl while D holds jal → pc_mux_sel = 1, squash_Dhl = 1, X receives a bubble next cycle, rf_wen_Whl never asserts for the jal.
- Writer to x0 followed by a reader of x0 → select 0. Writers to x7 in both X and W → select 1.
- Assert reset with all stages valid → next cycle all outputs at reset values, and rf_wen_Whl = 0 for 3 subsequent cycles absent new D instructions.
